// File: rtl/axis_insert_pkg.sv
// Shared types and helpers for the header-insert arbiter and its round-robin picker.
package axis_insert_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_e;

  localparam int N_SRC_DEF   = 4;
  localparam int DATA_WD_DEF = 32;
  localparam int MAX_SRC     = 32;

  // Round-robin winner: first set bit of req searching upward from last+1, modulo n.
  // Scanning offsets high-to-low lets the nearest requester overwrite farther ones.
  function automatic int rr_next(input logic [MAX_SRC-1:0] req, input int n, input int last);
    int idx;
    rr_next = 0;
    for (int k = MAX_SRC; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (req[idx]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/axis_insert_arbiter_if.sv
// Bundle of per-source and downstream stream/header handshakes around the arbiter.
interface axis_insert_arbiter_if #(
  parameter int N_SRC        = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic [N_SRC-1:0]              s_valid_in;
  logic [N_SRC*DATA_WD-1:0]      s_data_in;
  logic [N_SRC*DATA_BYTE_WD-1:0] s_keep_in;
  logic [N_SRC-1:0]              s_last_in;
  logic [N_SRC-1:0]              s_ready_in;

  logic [N_SRC-1:0]              s_valid_insert;
  logic [N_SRC*DATA_WD-1:0]      s_data_insert;
  logic [N_SRC*DATA_BYTE_WD-1:0] s_keep_insert;
  logic [N_SRC*BYTE_CNT_WD-1:0]  s_byte_insert_cnt;
  logic [N_SRC-1:0]              s_ready_insert;

  logic                          m_valid_in;
  logic [DATA_WD-1:0]            m_data_in;
  logic [DATA_BYTE_WD-1:0]       m_keep_in;
  logic                          m_last_in;
  logic                          m_ready_in;

  logic                          m_valid_insert;
  logic [DATA_WD-1:0]            m_data_insert;
  logic [DATA_BYTE_WD-1:0]       m_keep_insert;
  logic [BYTE_CNT_WD-1:0]        m_byte_insert_cnt;
  logic                          m_ready_insert;

  // master: the arbiter; slave: the sources plus the downstream insert block
  modport master (
    input  s_valid_in, s_data_in, s_keep_in, s_last_in,
    input  s_valid_insert, s_data_insert, s_keep_insert, s_byte_insert_cnt,
    input  m_ready_in, m_ready_insert,
    output s_ready_in, s_ready_insert,
    output m_valid_in, m_data_in, m_keep_in, m_last_in,
    output m_valid_insert, m_data_insert, m_keep_insert, m_byte_insert_cnt
  );

  modport slave (
    output s_valid_in, s_data_in, s_keep_in, s_last_in,
    output s_valid_insert, s_data_insert, s_keep_insert, s_byte_insert_cnt,
    output m_ready_in, m_ready_insert,
    input  s_ready_in, s_ready_insert,
    input  m_valid_in, m_data_in, m_keep_in, m_last_in,
    input  m_valid_insert, m_data_insert, m_keep_insert, m_byte_insert_cnt
  );
endinterface

// File: rtl/axis_insert_arbiter_rr_pick.sv
// Combinational round-robin picker: request vector + last grant -> winner index and valid.
module rr_pick
  import axis_insert_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] win,
  output logic          win_vld
);
  logic [MAX_SRC-1:0] req_w;

  always_comb begin
    req_w        = '0;
    req_w[N-1:0] = req;
    win          = IW'(rr_next(req_w, N, 32'(last)));
    win_vld      = |req;
  end
endmodule

// File: rtl/axis_insert_arbiter.sv
// Packet-level round-robin arbiter: grants one source, forwards its header then its data to last.
module axis_insert_arbiter
  import axis_insert_pkg::*;
#(
  parameter int N_SRC        = N_SRC_DEF,
  parameter int DATA_WD      = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int IDX_WD       = $clog2(N_SRC)
) (
  input  logic              clk,
  input  logic              rst,
  axis_insert_arbiter_if.master bus,
  output logic              grant_valid,
  output logic [IDX_WD-1:0] grant_idx,
  output logic [15:0]       pkt_cnt
);
  state_e              state_q;
  logic [IDX_WD-1:0]   grant_q;
  logic [IDX_WD-1:0]   last_q;
  logic [15:0]         cnt_q;
  logic [IDX_WD-1:0]   pick_idx;
  logic                pick_vld;
  logic                hdr_hs;
  logic                last_hs;
  logic [31:0]         g;

  rr_pick #(.N(N_SRC), .IW(IDX_WD)) u_pick (
    .req     (bus.s_valid_insert),
    .last    (last_q),
    .win     (pick_idx),
    .win_vld (pick_vld)
  );

  assign g       = 32'(grant_q);
  assign hdr_hs  = (state_q == ST_HDR)  && bus.s_valid_insert[grant_q] && bus.m_ready_insert;
  assign last_hs = (state_q == ST_DATA) && bus.s_valid_in[grant_q] && bus.s_last_in[grant_q]
                   && bus.m_ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_WD'(N_SRC - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (pick_vld) begin
          grant_q <= pick_idx;
          state_q <= ST_HDR;
        end
        // a granted source that withdraws its header keeps the grant
        ST_HDR:  if (hdr_hs) state_q <= ST_DATA;
        ST_DATA: if (last_hs) begin
          state_q <= ST_IDLE;
          last_q  <= grant_q;
          cnt_q   <= cnt_q + 16'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.s_ready_in        = '0;
    bus.s_ready_insert    = '0;
    bus.m_valid_insert    = (state_q == ST_HDR)  && bus.s_valid_insert[grant_q];
    bus.m_valid_in        = (state_q == ST_DATA) && bus.s_valid_in[grant_q];
    bus.m_data_insert     = bus.s_data_insert[g*DATA_WD +: DATA_WD];
    bus.m_keep_insert     = bus.s_keep_insert[g*DATA_BYTE_WD +: DATA_BYTE_WD];
    bus.m_byte_insert_cnt = bus.s_byte_insert_cnt[g*BYTE_CNT_WD +: BYTE_CNT_WD];
    bus.m_data_in         = bus.s_data_in[g*DATA_WD +: DATA_WD];
    bus.m_keep_in         = bus.s_keep_in[g*DATA_BYTE_WD +: DATA_BYTE_WD];
    bus.m_last_in         = bus.s_last_in[grant_q];
    if (state_q == ST_HDR)  bus.s_ready_insert[grant_q] = bus.m_ready_insert;
    if (state_q == ST_DATA) bus.s_ready_in[grant_q]     = bus.m_ready_in;
  end

  assign grant_valid = (state_q != ST_IDLE);
  assign grant_idx   = grant_q;
  assign pkt_cnt     = cnt_q;
endmodule

// File: tb/tb_axis_insert_arbiter.sv
// Directed bench for axis_insert_arbiter: one task per scenario, inline checks.
module tb_axis_insert_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [15:0]   pkt_cnt;
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  axis_insert_arbiter_if #(.N_SRC(N), .DATA_WD(DW)) bus();

  axis_insert_arbiter #(.N_SRC(N), .DATA_WD(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .pkt_cnt     (pkt_cnt)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear();
    bus.s_valid_in        = '0;
    bus.s_data_in         = '0;
    bus.s_keep_in         = '0;
    bus.s_last_in         = '0;
    bus.s_valid_insert    = '0;
    bus.s_data_insert     = '0;
    bus.s_keep_insert     = '0;
    bus.s_byte_insert_cnt = '0;
    bus.m_ready_in        = 1'b0;
    bus.m_ready_insert    = 1'b0;
  endtask

  task automatic run_one_beat(input int src);
    clear();
    bus.m_ready_in = 1'b1;
    bus.m_ready_insert = 1'b1;
    bus.s_valid_insert[src] = 1'b1;
    bus.s_valid_in[src] = 1'b1;
    bus.s_last_in[src] = 1'b1;
    step();
    step();
    bus.s_valid_insert[src] = 1'b0;
    step();
    clear();
    #1;
  endtask

  task automatic test_reset();
    clear();
    bus.m_ready_in = 1'b1;
    bus.m_ready_insert = 1'b1;
    bus.s_valid_in = '1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    if (grant_valid !== 1'b0) begin bad++; $display("FAIL rst_gv got=%b exp=0", grant_valid); end total++;
    if (grant_idx !== 2'd0) begin bad++; $display("FAIL rst_gidx got=%0d exp=0", grant_idx); end total++;
    if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", pkt_cnt); end total++;
    if (bus.m_valid_in !== 1'b0) begin bad++; $display("FAIL rst_mvin got=%b exp=0", bus.m_valid_in); end total++;
    if (bus.m_valid_insert !== 1'b0) begin bad++; $display("FAIL rst_mvins got=%b exp=0", bus.m_valid_insert); end total++;
    if (bus.s_ready_in !== 4'b0) begin bad++; $display("FAIL rst_srin got=%b exp=0000", bus.s_ready_in); end total++;
    if (bus.s_ready_insert !== 4'b0) begin bad++; $display("FAIL rst_srins got=%b exp=0000", bus.s_ready_insert); end total++;
    step();
    if (grant_valid !== 1'b0) begin bad++; $display("FAIL data_only_no_req got=%b exp=0", grant_valid); end total++;
    clear();
  endtask

  task automatic test_single();
    clear();
    bus.m_ready_in = 1'b1;
    bus.m_ready_insert = 1'b1;
    bus.s_valid_insert[2] = 1'b1;
    bus.s_data_insert[2*DW +: DW] = 32'hA5A5A5A5;
    bus.s_keep_insert[8 +: 4] = 4'hF;
    bus.s_byte_insert_cnt[4 +: 2] = 2'd2;
    bus.s_valid_in[2] = 1'b1;
    bus.s_data_in[2*DW +: DW] = 32'h1000_0000;
    #1;
    if (grant_valid !== 1'b0) begin bad++; $display("FAIL single_pre_gv got=%b exp=0", grant_valid); end total++;
    step();
    #1;
    if (grant_idx !== 2'd2 || grant_valid !== 1'b1) begin bad++; $display("FAIL single_grant got=%0d/%b exp=2/1", grant_idx, grant_valid); end total++;
    if (bus.m_valid_insert !== 1'b1 || bus.m_data_insert !== 32'hA5A5A5A5) begin bad++; $display("FAIL single_hdr got=%b/%h exp=1/a5a5a5a5", bus.m_valid_insert, bus.m_data_insert); end total++;
    if (bus.m_byte_insert_cnt !== 2'd2 || bus.m_keep_insert !== 4'hF) begin bad++; $display("FAIL single_hdr_cnt got=%0d/%h exp=2/f", bus.m_byte_insert_cnt, bus.m_keep_insert); end total++;
    if (bus.s_ready_insert !== 4'b0100) begin bad++; $display("FAIL single_srins got=%b exp=0100", bus.s_ready_insert); end total++;
    if (bus.m_valid_in !== 1'b0 || bus.s_ready_in !== 4'b0) begin bad++; $display("FAIL single_hdr_nodata got=%b/%b exp=0/0000", bus.m_valid_in, bus.s_ready_in); end total++;
    step();
    bus.s_valid_insert[2] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.s_data_in[2*DW +: DW] = 32'h1000_0000 + 32'(b);
      bus.s_keep_in[8 +: 4] = 4'hF;
      bus.s_last_in[2] = (b == 2);
      #1;
      if (bus.m_valid_in !== 1'b1 || bus.m_data_in !== 32'h1000_0000 + 32'(b)) begin bad++; $display("FAIL single_beat%0d got=%b/%h exp=1/%h", b, bus.m_valid_in, bus.m_data_in, 32'h1000_0000 + 32'(b)); end total++;
      if (bus.m_last_in !== (b == 2) || bus.s_ready_in !== 4'b0100 || bus.m_valid_insert !== 1'b0) begin bad++; $display("FAIL single_ctl%0d got last=%b srdy=%b mvins=%b", b, bus.m_last_in, bus.s_ready_in, bus.m_valid_insert); end total++;
      step();
    end
    clear();
    #1;
    if (grant_valid !== 1'b0 || pkt_cnt !== 16'd1) begin bad++; $display("FAIL single_done got=%b/%0d exp=0/1", grant_valid, pkt_cnt); end total++;
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear();
    bus.m_ready_in = 1'b1;
    bus.m_ready_insert = 1'b1;
    bus.s_valid_insert = '1;
    bus.s_valid_in = '1;
    bus.s_last_in = '1;
    for (int i = 0; i < N; i++) bus.s_data_in[i*DW +: DW] = 32'hC0 + 32'(i);
    for (int p = 0; p < 8; p++) begin
      #1;
      if (grant_valid !== 1'b0) begin bad++; $display("FAIL rr_bubble%0d got=%b exp=0", p, grant_valid); end total++;
      step();
      if (grant_idx !== IW'(p % 4)) begin bad++; $display("FAIL rr_order%0d got=%0d exp=%0d", p, grant_idx, p % 4); end total++;
      step();
      #1;
      if (bus.m_valid_in !== 1'b1 || bus.m_data_in !== 32'hC0 + 32'(p % 4)) begin bad++; $display("FAIL rr_data%0d got=%b/%h exp=1/%h", p, bus.m_valid_in, bus.m_data_in, 32'hC0 + 32'(p % 4)); end total++;
      step();
    end
    clear();
    #1;
    if (pkt_cnt !== 16'd8) begin bad++; $display("FAIL rr_cnt got=%0d exp=8", pkt_cnt); end total++;
  endtask

  task automatic test_backpressure();
    int b = 0;
    int cyc = 0;
    clear();
    bus.m_ready_insert = 1'b1;
    bus.s_valid_insert[1] = 1'b1;
    bus.s_valid_in[0] = 1'b1;
    bus.s_valid_in[3] = 1'b1;
    step();
    if (grant_idx !== 2'd1) begin bad++; $display("FAIL bp_grant got=%0d exp=1", grant_idx); end total++;
    step();
    bus.s_valid_insert[1] = 1'b0;
    while (b < 4 && cyc < 20) begin
      bus.m_ready_in = (cyc % 2 == 0);
      bus.s_valid_in[1] = 1'b1;
      bus.s_data_in[DW +: DW] = 32'hB000 + 32'(b);
      bus.s_last_in[1] = (b == 3);
      #1;
      if (bus.s_ready_in !== (bus.m_ready_in ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL bp_srdy%0d got=%b mrdy=%b", cyc, bus.s_ready_in, bus.m_ready_in); end total++;
      if (bus.m_valid_in !== 1'b1 || bus.m_data_in !== 32'hB000 + 32'(b)) begin bad++; $display("FAIL bp_data%0d got=%b/%h exp=1/%h", cyc, bus.m_valid_in, bus.m_data_in, 32'hB000 + 32'(b)); end total++;
      if (bus.m_ready_in) b++;
      cyc++;
      step();
    end
    clear();
    #1;
    if (b !== 4 || cyc !== 7) begin bad++; $display("FAIL bp_beats got=%0d/%0d exp=4/7", b, cyc); end total++;
    if (grant_valid !== 1'b0 || pkt_cnt !== 16'd9) begin bad++; $display("FAIL bp_done got=%b/%0d exp=0/9", grant_valid, pkt_cnt); end total++;
  endtask

  task automatic test_stalled_header();
    clear();
    bus.m_ready_insert = 1'b1;
    bus.m_ready_in = 1'b1;
    bus.s_valid_insert = 4'b1010;
    step();
    if (grant_idx !== 2'd3) begin bad++; $display("FAIL stall_grant got=%0d exp=3", grant_idx); end total++;
    bus.s_valid_insert[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus.m_valid_insert !== 1'b0 || bus.s_ready_insert !== 4'b1000) begin bad++; $display("FAIL stall_hold%0d got=%b/%b exp=0/1000", k, bus.m_valid_insert, bus.s_ready_insert); end total++;
      if (grant_valid !== 1'b1 || grant_idx !== 2'd3) begin bad++; $display("FAIL stall_grant%0d got=%b/%0d exp=1/3", k, grant_valid, grant_idx); end total++;
      step();
    end
    bus.s_valid_insert[3] = 1'b1;
    #1;
    if (bus.m_valid_insert !== 1'b1) begin bad++; $display("FAIL stall_resume got=%b exp=1", bus.m_valid_insert); end total++;
    step();
    bus.s_valid_insert[3] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.s_valid_in[3] = 1'b1;
      bus.s_data_in[3*DW +: DW] = 32'hE0 + 32'(b);
      bus.s_last_in[3] = (b == 1);
      #1;
      if (bus.s_ready_in !== 4'b1000 || grant_idx !== 2'd3) begin bad++; $display("FAIL stall_data%0d got=%b/%0d exp=1000/3", b, bus.s_ready_in, grant_idx); end total++;
      step();
    end
    bus.s_valid_in[3] = 1'b0;
    bus.s_last_in[3] = 1'b0;
    #1;
    if (grant_valid !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b exp=0", grant_valid); end total++;
    step();
    if (grant_idx !== 2'd1 || grant_valid !== 1'b1) begin bad++; $display("FAIL stall_next got=%0d/%b exp=1/1", grant_idx, grant_valid); end total++;
    step();
    bus.s_valid_insert = '0;
    bus.s_valid_in[1] = 1'b1;
    bus.s_last_in[1] = 1'b1;
    bus.s_data_in[DW +: DW] = 32'hD1;
    #1;
    if (bus.m_valid_in !== 1'b1 || bus.m_data_in !== 32'hD1) begin bad++; $display("FAIL stall_src1 got=%b/%h exp=1/d1", bus.m_valid_in, bus.m_data_in); end total++;
    step();
    clear();
    #1;
    if (grant_valid !== 1'b0 || pkt_cnt !== 16'd11) begin bad++; $display("FAIL stall_done got=%b/%0d exp=0/11", grant_valid, pkt_cnt); end total++;
  endtask

  task automatic test_reset_mid_packet();
    clear();
    bus.m_ready_in = 1'b1;
    bus.m_ready_insert = 1'b1;
    bus.s_valid_insert[2] = 1'b1;
    step();
    if (grant_idx !== 2'd2) begin bad++; $display("FAIL rmid_grant got=%0d exp=2", grant_idx); end total++;
    step();
    bus.s_valid_insert[2] = 1'b0;
    bus.s_valid_in[2] = 1'b1;
    bus.s_data_in[2*DW +: DW] = 32'hF0;
    step();
    bus.s_data_in[2*DW +: DW] = 32'hF1;
    rst = 1'b1;
    step();
    #1;
    if (grant_valid !== 1'b0 || pkt_cnt !== 16'd0) begin bad++; $display("FAIL rmid_state got=%b/%0d exp=0/0", grant_valid, pkt_cnt); end total++;
    if (bus.m_valid_in !== 1'b0 || bus.m_valid_insert !== 1'b0) begin bad++; $display("FAIL rmid_valids got=%b/%b exp=0/0", bus.m_valid_in, bus.m_valid_insert); end total++;
    if (bus.s_ready_in !== 4'b0 || bus.s_ready_insert !== 4'b0) begin bad++; $display("FAIL rmid_readies got=%b/%b exp=0000/0000", bus.s_ready_in, bus.s_ready_insert); end total++;
    rst = 1'b0;
    clear();
    bus.s_valid_insert = 4'b0101;
    step();
    if (grant_idx !== 2'd0 || grant_valid !== 1'b1) begin bad++; $display("FAIL rmid_regrant got=%0d/%b exp=0/1", grant_idx, grant_valid); end total++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear();
  endtask

  task automatic test_wrap();
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    run_one_beat(0);
    if (pkt_cnt !== 16'hFFFF || grant_idx !== 2'd0) begin bad++; $display("FAIL wrap_ffff got=%h/%0d exp=ffff/0", pkt_cnt, grant_idx); end total++;
    run_one_beat(1);
    if (pkt_cnt !== 16'h0000 || grant_idx !== 2'd1) begin bad++; $display("FAIL wrap_zero got=%h/%0d exp=0000/1", pkt_cnt, grant_idx); end total++;
  endtask

  initial begin
    rst = 1'b1;
    clear();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stalled_header();
    test_reset_mid_packet();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
